memory_access_unit: RTL and testbench

Memory-stage datapath/control block that consumes the execute-to-memory pipeline latch and performs the data-memory access for loads and stores. It generates word-aligned bus requests with byte strobes, waits on a ready handshake, and formats returned load data (byte/half/word, signed/unsigned). While an access is outstanding it raises a stall to the hazard unit. It detects misaligned accesses and reports them to the exception logic instead of touching the bus.

---
 rtl/memory_access_unit_if.sv | 21 ++
 rtl/memory_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_memory_access_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the memory stage and the data memory.
// Word-aligned request with byte strobes, completed by a single-cycle ready.
interface memory_access_unit_if;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_strobe;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_ren, dmem_wen, dmem_addr, dmem_wdata, dmem_strobe,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_ren, dmem_wen, dmem_addr, dmem_wdata, dmem_strobe,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: issues aligned bus requests, formats load data,
// stalls while the bus is busy and flags misaligned accesses.
module memory_access_unit (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        ex_valid,
    input  logic                        ex_dread,
    input  logic [1:0]                  ex_dwrite,
    input  logic [31:0]                 ex_alu_out,
    input  logic [31:0]                 ex_rdat2,
    input  logic [1:0]                  ex_reg_wr_mem,
    input  logic                        ex_reg_wr_mem_signed,
    input  logic                        mem_en,
    input  logic                        flush,
    memory_access_unit_if.master        dmem,
    output logic                        mem_stall,
    output logic [31:0]                 load_data,
    output logic                        fault_load,
    output logic                        fault_store
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, ABORT} state_e;

    function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lane, 3'b000} +: 8];
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0:    fmt_load = {{24{sgn & b[7]}}, b};
            2'd1:    fmt_load = {{16{sgn & h[15]}}, h};
            default: fmt_load = rdata;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strobe_q, strobe_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] ldata_q, ldata_d;

    logic        is_load, is_store, access, ld_mis, st_mis, go;
    logic [31:0] new_wdata;
    logic [3:0]  new_strobe;
    logic [31:0] new_fmt, q_fmt;

    // Load wins when an instruction claims both a load and a store.
    always_comb begin
        is_load  = ex_dread;
        is_store = !ex_dread && (ex_dwrite != 2'd0);
        access   = ex_valid && (ex_dread || ex_dwrite != 2'd0) && !flush;
        ld_mis   = (ex_reg_wr_mem == 2'd1 && ex_alu_out[0]) ||
                   (ex_reg_wr_mem[1] && ex_alu_out[1:0] != 2'd0);
        st_mis   = (ex_dwrite == 2'd2 && ex_alu_out[0]) ||
                   (ex_dwrite == 2'd3 && ex_alu_out[1:0] != 2'd0);
        go       = access && (is_load ? !ld_mis : !st_mis);
        new_wdata  = 32'd0;
        new_strobe = 4'd0;
        if (is_store) begin
            case (ex_dwrite)
                2'd1: begin
                    new_wdata  = {4{ex_rdat2[7:0]}};
                    new_strobe = 4'b0001 << ex_alu_out[1:0];
                end
                2'd2: begin
                    new_wdata  = {2{ex_rdat2[15:0]}};
                    new_strobe = ex_alu_out[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    new_wdata  = ex_rdat2;
                    new_strobe = 4'b1111;
                end
            endcase
        end
        new_fmt = fmt_load(dmem.dmem_rdata, ex_reg_wr_mem, ex_reg_wr_mem_signed, ex_alu_out[1:0]);
        q_fmt   = fmt_load(dmem.dmem_rdata, size_q, sgn_q, lane_q);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strobe_d = strobe_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        lane_d   = lane_q;
        ldata_d  = ldata_q;
        dmem.dmem_ren    = 1'b0;
        dmem.dmem_wen    = 1'b0;
        dmem.dmem_addr   = 32'd0;
        dmem.dmem_wdata  = 32'd0;
        dmem.dmem_strobe = 4'd0;
        mem_stall   = 1'b0;
        load_data   = 32'd0;
        fault_load  = 1'b0;
        fault_store = 1'b0;
        case (state_q)
            IDLE: begin
                fault_load  = access && is_load && ld_mis;
                fault_store = access && is_store && st_mis;
                if (go) begin
                    dmem.dmem_ren    = is_load;
                    dmem.dmem_wen    = is_store;
                    dmem.dmem_addr   = {ex_alu_out[31:2], 2'b00};
                    dmem.dmem_wdata  = new_wdata;
                    dmem.dmem_strobe = new_strobe;
                    addr_d   = {ex_alu_out[31:2], 2'b00};
                    wdata_d  = new_wdata;
                    strobe_d = new_strobe;
                    ren_d    = is_load;
                    wen_d    = is_store;
                    size_d   = ex_reg_wr_mem;
                    sgn_d    = ex_reg_wr_mem_signed;
                    lane_d   = ex_alu_out[1:0];
                    mem_stall = !dmem.dmem_ready;
                    if (dmem.dmem_ready) begin
                        load_data = is_load ? new_fmt : 32'd0;
                        if (!mem_en) begin
                            state_d = DONE;
                            ldata_d = load_data;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                dmem.dmem_ren    = ren_q;
                dmem.dmem_wen    = wen_q;
                dmem.dmem_addr   = addr_q;
                dmem.dmem_wdata  = wdata_q;
                dmem.dmem_strobe = strobe_q;
                if (dmem.dmem_ready) begin
                    // A flush landing with ready completes the bus cycle but drops the data.
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        load_data = ren_q ? q_fmt : 32'd0;
                        ldata_d   = load_data;
                        state_d   = mem_en ? IDLE : DONE;
                    end
                end else begin
                    mem_stall = 1'b1;
                    if (flush) state_d = ABORT;
                end
            end
            DONE: begin
                load_data = ldata_q;
                if (mem_en || flush) state_d = IDLE;
            end
            default: begin
                dmem.dmem_ren    = ren_q;
                dmem.dmem_wen    = wen_q;
                dmem.dmem_addr   = addr_q;
                dmem.dmem_wdata  = wdata_q;
                dmem.dmem_strobe = strobe_q;
                mem_stall = 1'b1;
                if (dmem.dmem_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            strobe_q <= 4'd0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            size_q   <= 2'd0;
            sgn_q    <= 1'b0;
            lane_q   <= 2'd0;
            ldata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            lane_q   <= lane_d;
            ldata_q  <= ldata_d;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Randomized bench for memory_access_unit; the bench plays the bus slave and
// predicts every cycle of a transaction from its latency, hold and flush timing.
module tb_memory_access_unit;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        ex_valid, ex_dread, ex_reg_wr_mem_signed, mem_en, flush;
    logic [1:0]  ex_dwrite, ex_reg_wr_mem;
    logic [31:0] ex_alu_out, ex_rdat2, load_data;
    logic        mem_stall, fault_load, fault_store;
    int          n_chk = 0;
    int          n_err = 0;

    memory_access_unit_if dmem_if();

    memory_access_unit dut (
        .CLK(CLK), .nRST(nRST),
        .ex_valid(ex_valid), .ex_dread(ex_dread), .ex_dwrite(ex_dwrite),
        .ex_alu_out(ex_alu_out), .ex_rdat2(ex_rdat2), .ex_reg_wr_mem(ex_reg_wr_mem),
        .ex_reg_wr_mem_signed(ex_reg_wr_mem_signed), .mem_en(mem_en), .flush(flush),
        .dmem(dmem_if), .mem_stall(mem_stall), .load_data(load_data),
        .fault_load(fault_load), .fault_store(fault_store)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rd, input int sz, input bit sgn,
                                               input logic [31:0] addr);
        logic [31:0] v;
        int off;
        off = int'(addr[1:0]);
        if (sz == 0) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (sgn && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic rand_ex();
        ex_valid = 1'($urandom);
        ex_dread = 1'($urandom);
        ex_dwrite = 2'($urandom);
        ex_alu_out = $urandom;
        ex_rdat2 = $urandom;
        ex_reg_wr_mem = 2'($urandom_range(0, 2));
        ex_reg_wr_mem_signed = 1'($urandom);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bubble();
        ex_valid = 1'b0; flush = 1'b0; mem_en = 1'b1;
        dmem_if.dmem_ready = 1'b0; dmem_if.dmem_rdata = $urandom;
        @(negedge CLK);
        chk("idle_ren", 32'(dmem_if.dmem_ren), 0);
        chk("idle_wen", 32'(dmem_if.dmem_wen), 0);
        chk("idle_stall", 32'(mem_stall), 0);
        chk("idle_ldata", load_data, 0);
        step();
    endtask

    // sz: load size 0..2 for loads, store size 1..3 for stores; fl: flush cycle or -1.
    task automatic run_txn(input bit ld, input int sz, input bit sgn, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int k, input int hold, input int fl);
        logic [31:0] exp_ld, exp_wd;
        logic [3:0]  exp_sb;
        int          off;
        off = int'(addr[1:0]);
        exp_ld = ld ? model_load(rd, sz, sgn, addr) : 32'd0;
        if (sz == 1)      begin exp_wd = (wd & 32'hFF) * 32'h01010101;  exp_sb = 4'(1 << off); end
        else if (sz == 2) begin exp_wd = (wd & 32'hFFFF) * 32'h00010001; exp_sb = (off >= 2) ? 4'hC : 4'h3; end
        else              begin exp_wd = wd; exp_sb = 4'hF; end
        for (int c = 0; c <= k; c++) begin
            if (c == 0) begin
                ex_valid = 1'b1; ex_dread = ld;
                ex_dwrite = ld ? 2'($urandom) : 2'(sz);
                ex_alu_out = addr; ex_rdat2 = wd;
                ex_reg_wr_mem = ld ? 2'(sz) : 2'($urandom_range(0, 2));
                ex_reg_wr_mem_signed = sgn;
            end else begin
                rand_ex();
            end
            flush = (c == fl);
            mem_en = (c == k && hold == 0);
            dmem_if.dmem_ready = (c == k);
            dmem_if.dmem_rdata = (c == k) ? rd : $urandom;
            @(negedge CLK);
            chk("req_ren", 32'(dmem_if.dmem_ren), 32'(ld));
            chk("req_wen", 32'(dmem_if.dmem_wen), 32'(!ld));
            chk("req_addr", dmem_if.dmem_addr, addr & 32'hFFFFFFFC);
            if (!ld) begin
                chk("req_wdata", dmem_if.dmem_wdata, exp_wd);
                chk("req_strobe", 32'(dmem_if.dmem_strobe), 32'(exp_sb));
            end
            chk("stall", 32'(mem_stall), 32'((c < k) || (fl >= 0 && fl < k)));
            chk("ldata", load_data, (c == k && fl < 0) ? exp_ld : 32'd0);
            chk("no_fault", 32'({fault_load, fault_store}), 0);
            step();
        end
        for (int h = 1; h <= hold; h++) begin
            rand_ex();
            flush = 1'b0;
            mem_en = (h == hold);
            dmem_if.dmem_ready = 1'b0; dmem_if.dmem_rdata = $urandom;
            @(negedge CLK);
            chk("hold_ren", 32'(dmem_if.dmem_ren), 0);
            chk("hold_wen", 32'(dmem_if.dmem_wen), 0);
            chk("hold_stall", 32'(mem_stall), 0);
            chk("hold_ldata", load_data, exp_ld);
            step();
        end
        bubble();
    endtask

    task automatic run_mis(input bit ld, input int sz, input logic [31:0] addr);
        ex_valid = 1'b1; ex_dread = ld;
        ex_dwrite = ld ? 2'($urandom) : 2'(sz);
        ex_alu_out = addr; ex_rdat2 = $urandom;
        ex_reg_wr_mem = ld ? 2'(sz) : 2'($urandom_range(0, 2));
        ex_reg_wr_mem_signed = 1'($urandom);
        flush = 1'b0; mem_en = 1'b1;
        dmem_if.dmem_ready = 1'($urandom); dmem_if.dmem_rdata = $urandom;
        @(negedge CLK);
        chk("mis_fault_load", 32'(fault_load), 32'(ld));
        chk("mis_fault_store", 32'(fault_store), 32'(!ld));
        chk("mis_ren", 32'(dmem_if.dmem_ren), 0);
        chk("mis_wen", 32'(dmem_if.dmem_wen), 0);
        chk("mis_stall", 32'(mem_stall), 0);
        step();
        bubble();
    endtask

    initial begin
        logic [31:0] a;
        int kind, sz, k;
        nRST = 1'b0;
        ex_valid = 0; ex_dread = 0; ex_dwrite = 0; ex_alu_out = 0; ex_rdat2 = 0;
        ex_reg_wr_mem = 0; ex_reg_wr_mem_signed = 0; mem_en = 0; flush = 0;
        dmem_if.dmem_ready = 0; dmem_if.dmem_rdata = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ren", 32'(dmem_if.dmem_ren), 0);
        chk("rst_wen", 32'(dmem_if.dmem_wen), 0);
        chk("rst_addr", dmem_if.dmem_addr, 0);
        chk("rst_strobe", 32'(dmem_if.dmem_strobe), 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_ldata", load_data, 0);
        chk("rst_faults", 32'({fault_load, fault_store}), 0);
        nRST = 1'b1;
        step();

        run_txn(1, 2, 0, 32'h100, 0, 32'h8899AABB, 2, 0, -1);
        run_txn(1, 0, 1, 32'h103, 0, 32'h80112233, 0, 0, -1);
        run_txn(1, 0, 0, 32'h103, 0, 32'h80112233, 0, 0, -1);
        run_txn(0, 2, 0, 32'h202, 32'h1234ABCD, 0, 0, 0, -1);
        run_mis(1, 2, 32'h101);
        run_mis(0, 2, 32'h203);
        run_txn(0, 3, 0, 32'h400, 32'hCAFEF00D, 0, 0, 3, -1);
        run_txn(1, 1, 1, 32'h302, 0, 32'h9ABC1234, 1, 2, -1);
        run_txn(1, 2, 0, 32'h500, 0, 32'hDEADBEEF, 5, 0, 1);
        run_txn(1, 2, 0, 32'h504, 0, 32'h12345678, 3, 0, 3);

        // Flushed instruction in IDLE never reaches the bus.
        ex_valid = 1; ex_dread = 1; ex_dwrite = 0; ex_alu_out = 32'h600; ex_reg_wr_mem = 2;
        flush = 1; mem_en = 1; dmem_if.dmem_ready = 0;
        @(negedge CLK);
        chk("flush_idle_ren", 32'(dmem_if.dmem_ren), 0);
        chk("flush_idle_stall", 32'(mem_stall), 0);
        step();
        bubble();

        // Reset mid-transaction drops the request at once.
        ex_valid = 1; ex_dread = 1; ex_alu_out = 32'h700; ex_reg_wr_mem = 2; flush = 0; mem_en = 0;
        dmem_if.dmem_ready = 0;
        step();
        ex_valid = 0; nRST = 1'b0;
        #1;
        chk("rst_mid_ren", 32'(dmem_if.dmem_ren), 0);
        chk("rst_mid_stall", 32'(mem_stall), 0);
        @(negedge CLK);
        nRST = 1'b1;
        step();
        bubble();

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 7);
            a = $urandom;
            if (kind == 6) begin
                if ($urandom_range(0, 1) == 1) begin
                    sz = $urandom_range(1, 2);
                    if (sz == 1) a[0] = 1'b1; else if (a[1:0] == 2'd0) a[1:0] = 2'(1 + $urandom_range(0, 2));
                    run_mis(1, sz, a);
                end else begin
                    sz = $urandom_range(2, 3);
                    if (sz == 2) a[0] = 1'b1; else if (a[1:0] == 2'd0) a[1:0] = 2'(1 + $urandom_range(0, 2));
                    run_mis(0, sz, a);
                end
            end else if (kind == 7) begin
                sz = $urandom_range(0, 2);
                if (sz == 1) a[0] = 1'b0; else if (sz == 2) a[1:0] = 2'd0;
                k = $urandom_range(1, 4);
                run_txn(1, sz, 1'($urandom), a, 0, $urandom, k, 0, $urandom_range(1, k));
            end else if (kind < 3) begin
                sz = $urandom_range(0, 2);
                if (sz == 1) a[0] = 1'b0; else if (sz == 2) a[1:0] = 2'd0;
                run_txn(1, sz, 1'($urandom), a, 0, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), -1);
            end else begin
                sz = $urandom_range(1, 3);
                if (sz == 2) a[0] = 1'b0; else if (sz == 3) a[1:0] = 2'd0;
                run_txn(0, sz, 0, a, $urandom, 0, $urandom_range(0, 3), $urandom_range(0, 2), -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
